spi_master_mc: RTL and testbench
================================

# spi_master_mc

Parametrised multi-slave SPI master in PL fabric, clocked from the PS AXI clock, for use where the fixed PS SPI controller routed through EMIO is too narrow. It generalises the existing SPI pinout: configurable word width, clock divider and chip-select count, with runtime CPOL/CPHA mode per command. Optional chip-select hold lets a driver chain words into one frame. Pin-side outputs use the same `_o`/`_t`/`_i` tristate split as the EMIO SPI signals, so they drop straight onto the top-level IOBUFs and ILA probes.

## Interface
- DATA_W, 8: bits per word, 4..32, MSB first.
- NUM_SS, 3: number of chip selects, 1..8.
- CLK_DIV, 4: SCK half-period in axi_aclk cycles, >=1.
- SS_W, $clog2(NUM_SS) (min 1): width of cmd_ss.

Ports:
- axi_aclk  in  1  clock. One clock only; all logic is on this clock.
- axi_aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid && ready.
- cmd_data  in  DATA_W  word to transmit.
- cmd_ss  in  SS_W  chip-select index.
- cmd_mode  in  2  {cpol, cpha}.
- cmd_last  in  1  1 = release CS after this word (see Configuration).
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid in that cycle. No backpressure.
- rsp_data  out  DATA_W  word received on MISO.
- busy  out  1  high whenever state != IDLE.
- sck_o / sck_t  out  1 / 1  serial clock / tristate (1 = released).
- mosi_o / mosi_t  out  1 / 1  data out / tristate (io0).
- miso_i  in  1  data in (io1).
- ss_o  out  NUM_SS  active-low chip selects.
- ss_t  out  1  chip-select tristate.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, CHAIN, GAP.
- IDLE: cmd_ready=1. On accept, latch cmd_data, cmd_ss and cmd_mode, then go to SETUP.
- SETUP: ss_o[cmd_ss]=0. sck_o=cpol. If CPHA=0, mosi_o=MSB. sck_t=mosi_t=0. Lasts CLK_DIV cycles, then SHIFT.
- SHIFT: 2*DATA_W half-periods of CLK_DIV cycles each. sck_o toggles at the start of each half-period.
  - CPHA=0: sample miso_i on odd edges (leading); shift the next MOSI bit on even edges (trailing), except after the final edge.
  - CPHA=1: shift on leading edges, with MSB on the first; sample on trailing edges.
- HOLD: CLK_DIV cycles, sck_o=cpol. rsp_valid pulses on the last HOLD cycle with the full received word. The next state is CHAIN if the hold condition holds, otherwise GAP.
- CHAIN: CS stays low and cmd_ready=1. On accept, go straight to SHIFT with cmd_data loaded; for CPHA=0, mosi_o=MSB at accept. cmd_ss and cmd_mode are ignored and the latched values are kept. cmd_valid is never forced.
- GAP: all ss_o=1, mosi_t=sck_t=1. Lasts CLK_DIV cycles, then IDLE.
- Out-of-range cmd_ss (>= NUM_SS): no CS is asserted; the transfer still runs and rsp_valid is still produced.
- busy=1 in every state except IDLE.

## Timing
- Reset values: cmd_ready=0 while axi_aresetn=0, then 1 in IDLE. rsp_valid=0, rsp_data=0, busy=0, sck_o=0, sck_t=1, mosi_o=0, mosi_t=1, ss_o=all 1, ss_t=1.
- ss_t=0 from the first cycle after reset release.
- Accept to rsp_valid: exactly CLK_DIV*(2*DATA_W+2) cycles for a non-chained word. For a chained word, measured from the CHAIN accept: CLK_DIV*(2*DATA_W+1).
- Minimum CS-high time between frames: CLK_DIV cycles (GAP), plus one IDLE cycle.
- miso_i is sampled directly in the cycle the sample edge is generated. No synchroniser; board timing covers it.
- Reset asserted mid-transfer: all outputs go to their reset values asynchronously, and no rsp_valid is produced.

## Configuration
- SPI_CS_HOLD_EN defined: cmd_last is honoured. cmd_last=0 on a word causes HOLD→CHAIN.
- SPI_CS_HOLD_EN undefined: cmd_last is ignored and HOLD always goes to GAP. The CHAIN state is not synthesised. Every word is its own CS frame.

## Test plan
- Mode 0, DATA_W=8, CLK_DIV=2, cmd_data=0xA5, cmd_ss=1, MISO model returns 0x3C:
  - MOSI bits 1,0,1,0,0,1,0,1 appear on rising edges.
  - rsp_data=0x3C with rsp_valid exactly 36 cycles after accept.
  - Only ss_o[1] goes low.
- Modes 1, 2 and 3 with the same data: each sample falls on the correct edge; the idle sck_o level equals cpol; rsp_data=0x3C.
- SPI_CS_HOLD_EN, two words 0x12 (cmd_last=0) then 0x34 (cmd_last=1):
  - ss_o stays low across both words.
  - The second rsp_valid comes 34 cycles after the second accept.
  - A single CS frame is seen.
- Same stimulus without SPI_CS_HOLD_EN: CS goes high for >=2 cycles between the words; two separate frames are seen.
- axi_aresetn pulsed low mid-SHIFT: outputs are at reset values the same cycle, no rsp_valid, and the next command completes normally.
- cmd_ss=NUM_SS (out of range): no ss_o asserted, rsp_valid still pulses at the nominal latency.

Source files
------------

// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-slave SPI master, per-command CPOL/CPHA, single axi_aclk domain.
// Define SPI_CS_HOLD_EN to honour cmd_last and chain words inside one chip-select frame.
module spi_master_mc #(
    parameter int DATA_W  = 8,
    parameter int NUM_SS  = 3,
    parameter int CLK_DIV = 4,
    parameter int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [SS_W-1:0]   cmd_ss,
    input  logic [1:0]        cmd_mode,
    input  logic              cmd_last,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              sck_o,
    output logic              sck_t,
    output logic              mosi_o,
    output logic              mosi_t,
    input  logic              miso_i,
    output logic [NUM_SS-1:0] ss_o,
    output logic              ss_t
);
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, CHAIN, GAP} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_alive;
    logic              r_sck;
    logic              r_mosi;
    logic              r_cpha;
    logic [CNT_W-1:0]  r_divCnt;
    logic [EDGE_W-1:0] r_edgeCnt;
    logic [SS_W-1:0]   r_ss;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic              w_divDone;
    logic              w_lastEdge;
    logic              w_accept;
    logic              w_chainAccept;
    logic              w_hold;
    logic              w_edge;
    logic              w_leading;
    logic              w_final;
    logic              w_csActive;
    logic [EDGE_W-1:0] w_newIdx;

    assign w_divDone  = (r_divCnt == CNT_W'(CLK_DIV - 1));
    assign w_lastEdge = (r_edgeCnt == EDGE_W'(2 * DATA_W - 1));
    assign w_accept   = cmd_valid && cmd_ready;

`ifdef SPI_CS_HOLD_EN
    logic r_last;
    assign w_chainAccept = w_accept && (r_state == CHAIN);
    assign w_hold        = !r_last;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)
            r_last <= 1'b0;
        else if (w_accept)
            r_last <= cmd_last;
    end
`else
    logic w_unusedLast;
    assign w_unusedLast  = cmd_last;
    assign w_chainAccept = 1'b0;
    assign w_hold        = 1'b0;
`endif

    // Every SCK edge starts a new half-period; the first edge of a word comes from SETUP or a CHAIN accept.
    assign w_edge    = (r_state == SETUP && w_divDone) ||
                       (r_state == SHIFT && w_divDone && !w_lastEdge) ||
                       w_chainAccept;
    assign w_newIdx  = (r_state == SHIFT) ? r_edgeCnt + EDGE_W'(1) : '0;
    assign w_leading = !w_newIdx[0];
    assign w_final   = (w_newIdx == EDGE_W'(2 * DATA_W - 1));

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = SETUP;
            SETUP:   if (w_divDone) w_nextState = SHIFT;
            SHIFT:   if (w_divDone && w_lastEdge) w_nextState = HOLD;
            HOLD:    if (w_divDone) w_nextState = w_hold ? CHAIN : GAP;
`ifdef SPI_CS_HOLD_EN
            CHAIN:   if (w_chainAccept) w_nextState = SHIFT;
`endif
            GAP:     if (w_divDone) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // CPHA=0 preloads the MSB onto MOSI so the first leading edge can sample it.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_alive   <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_cpha    <= 1'b0;
            r_divCnt  <= '0;
            r_edgeCnt <= '0;
            r_ss      <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
        end else begin
            r_alive  <= 1'b1;
            r_divCnt <= (w_nextState != r_state || w_divDone) ? '0 : r_divCnt + CNT_W'(1);
            if (r_state == IDLE && w_accept) begin
                r_ss   <= cmd_ss;
                r_cpha <= cmd_mode[0];
                r_sck  <= cmd_mode[1];
                r_tx   <= cmd_mode[0] ? cmd_data : cmd_data << 1;
                r_mosi <= cmd_mode[0] ? 1'b0 : cmd_data[DATA_W-1];
            end
            if (w_edge) begin
                r_sck     <= ~r_sck;
                r_edgeCnt <= w_newIdx;
                if (w_leading != r_cpha)
                    r_rx <= {r_rx[DATA_W-2:0], miso_i};
                if (w_leading == r_cpha && !w_final) begin
                    r_mosi <= r_tx[DATA_W-1];
                    r_tx   <= r_tx << 1;
                end
            end
            if (w_chainAccept) begin
                r_tx   <= cmd_data << 1;
                r_mosi <= cmd_data[DATA_W-1];
            end
        end
    end

    always_comb begin
        w_csActive = (r_state == SETUP) || (r_state == SHIFT) ||
                     (r_state == HOLD)  || (r_state == CHAIN);
        cmd_ready  = r_alive && (r_state == IDLE);
        busy       = (r_state != IDLE);
        rsp_valid  = (r_state == HOLD) && w_divDone;
        rsp_data   = r_rx;
        sck_o      = r_sck;
        sck_t      = !w_csActive;
        mosi_o     = r_mosi;
        mosi_t     = !w_csActive;
        ss_t       = !r_alive;
`ifdef SPI_CS_HOLD_EN
        if (r_alive && r_state == CHAIN)
            cmd_ready = 1'b1;
        if (r_state == CHAIN && !r_cpha && cmd_valid)
            mosi_o = cmd_data[DATA_W-1];
`endif
        for (int i = 0; i < NUM_SS; i++)
            ss_o[i] = !(w_csActive && (r_ss == SS_W'(i)));
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: scoreboard bench for spi_master_mc with a mode-aware SPI slave model.
// Honours SPI_CS_HOLD_EN the same way the design does.
module tb_spi_master_mc;
    localparam int DW        = 8;
    localparam int NSS       = 3;
    localparam int CD        = 2;
    localparam int LAT_WORD  = CD * (2 * DW + 2);
    localparam int LAT_CHAIN = CD * (2 * DW + 1);
    localparam logic [7:0] SLV_WORD = 8'h3C;

    typedef struct {
        logic [7:0] data;
        int         acc;
        int         lat;
    } rsp_t;

    logic       axi_aclk;
    logic       axi_aresetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [1:0] cmd_ss;
    logic [1:0] cmd_mode;
    logic       cmd_last;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       sck_o;
    logic       sck_t;
    logic       mosi_o;
    logic       mosi_t;
    logic       miso_i;
    logic [2:0] ss_o;
    logic       ss_t;

    int         total;
    int         bad;
    int         cyc;
    rsp_t       rspQ[$];
    logic [7:0] mosiQ[$];
    rsp_t       rspE;

    logic       slvCpol;
    logic       slvCpha;
    logic       tbSel;
    logic       prevSel;
    logic       prevSck;
    logic       lead;
    logic [7:0] slvTx;
    logic [7:0] slvRx;
    int         slvOut;
    int         slvIn;
    int         frames;
    int         gapRun;
    int         minGap;
    int         f0;

    spi_master_mc #(.DATA_W(DW), .NUM_SS(NSS), .CLK_DIV(CD)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_ss(cmd_ss), .cmd_mode(cmd_mode), .cmd_last(cmd_last),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .sck_o(sck_o), .sck_t(sck_t), .mosi_o(mosi_o), .mosi_t(mosi_t),
        .miso_i(miso_i), .ss_o(ss_o), .ss_t(ss_t)
    );

    always #5 axi_aclk = ~axi_aclk;

    always @(posedge axi_aclk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ssMask(input logic [1:0] ss);
        if (ss < NSS)
            return ~(3'b001 << ss);
        return 3'b111;
    endfunction

    task slaveShiftOut();
        if (slvOut == DW) begin
            slvTx  = SLV_WORD;
            slvOut = 0;
        end
        miso_i = slvTx[7];
        slvTx  = slvTx << 1;
        slvOut++;
    endtask

    // Scoreboard consumer: every rsp_valid must match the oldest pending command.
    always @(negedge axi_aclk) begin
        if (rsp_valid) begin
            if (rspQ.size() == 0) begin
                checkOutput("spurious rsp_valid", 1, 0);
            end else begin
                rspE = rspQ.pop_front();
                checkOutput("rsp_data", rsp_data, rspE.data);
                checkOutput("rsp latency", cyc - rspE.acc, rspE.lat);
            end
        end
    end

    // Slave model, evaluated away from the clock edge; MISO idles high when deselected.
    always @(negedge axi_aclk) begin
        tbSel = (ss_o != 3'b111) && !ss_t;
        if (tbSel && !prevSel) begin
            if (frames > 0 && gapRun < minGap)
                minGap = gapRun;
            frames++;
            slvTx  = SLV_WORD;
            slvOut = 0;
            slvIn  = 0;
            if (!slvCpha)
                slaveShiftOut();
        end else if (tbSel && sck_o != prevSck) begin
            lead = (sck_o != slvCpol);
            if (lead != slvCpha) begin
                slvRx = {slvRx[6:0], mosi_o};
                slvIn++;
                if (slvIn == DW) begin
                    slvIn = 0;
                    if (mosiQ.size() == 0)
                        checkOutput("spurious mosi word", 1, 0);
                    else
                        checkOutput("mosi word", slvRx, mosiQ.pop_front());
                end
            end else begin
                slaveShiftOut();
            end
        end
        if (!tbSel) begin
            miso_i = 1'b1;
            gapRun = prevSel ? 1 : gapRun + 1;
        end
        prevSel = tbSel;
        prevSck = sck_o;
    end

    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] ss, input logic [1:0] mode,
                                 input logic last, input int lat, input logic expRsp, input logic setupChk);
        rsp_t e;
        int   waited;
        @(negedge axi_aclk);
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_ss    = ss;
        cmd_mode  = mode;
        cmd_last  = last;
        slvCpol   = mode[1];
        slvCpha   = mode[0];
        waited    = 0;
        while (!cmd_ready && waited < 1000) begin
            @(negedge axi_aclk);
            waited++;
        end
        checkOutput("cmd_ready before accept", cmd_ready, 1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        if (expRsp) begin
            e.data = (ss < NSS) ? SLV_WORD : 8'hFF;
            e.acc  = cyc;
            e.lat  = lat;
            rspQ.push_back(e);
            if (ss < NSS)
                mosiQ.push_back(data);
        end
        @(negedge axi_aclk);
        cmd_valid = 1'b0;
        if (setupChk) begin
            checkOutput("setup sck_o=cpol", sck_o, mode[1]);
            checkOutput("setup ss_o", ss_o, ssMask(ss));
            checkOutput("setup busy", busy, 1);
            checkOutput("setup sck_t", sck_t, 0);
            if (!mode[0])
                checkOutput("setup mosi=MSB", mosi_o, data[7]);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((rspQ.size() != 0 || busy) && n < 500) begin
            @(negedge axi_aclk);
            n++;
        end
        checkOutput("drain rsp queue", rspQ.size(), 0);
        checkOutput("drain mosi queue", mosiQ.size(), 0);
        checkOutput("drain busy", busy, 0);
        repeat (2) @(negedge axi_aclk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " cmd_ready"}, cmd_ready, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, " rsp_data"}, rsp_data, 0);
        checkOutput({tag, " sck_o"}, sck_o, 0);
        checkOutput({tag, " sck_t"}, sck_t, 1);
        checkOutput({tag, " mosi_o"}, mosi_o, 0);
        checkOutput({tag, " mosi_t"}, mosi_t, 1);
        checkOutput({tag, " ss_o"}, ss_o, 3'b111);
        checkOutput({tag, " ss_t"}, ss_t, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        axi_aclk = 1'b0; axi_aresetn = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
        cmd_ss = '0; cmd_mode = '0; cmd_last = 1'b1; miso_i = 1'b1;
        total = 0; bad = 0; cyc = 0; slvCpol = 1'b0; slvCpha = 1'b0;
        prevSel = 1'b0; prevSck = 1'b0; slvTx = '0; slvRx = '0; slvOut = 0; slvIn = 0;
        frames = 0; gapRun = 0; minGap = 1000;

        repeat (3) @(negedge axi_aclk);
        checkResetValues("reset");
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        checkOutput("ss_t after release", ss_t, 0);
        checkOutput("cmd_ready in idle", cmd_ready, 1);

        for (int m = 0; m < 4; m++) begin
            applyStimulus(8'hA5, 2'd1, 2'(m), 1'b1, LAT_WORD, 1'b1, 1'b1);
            waitDrain();
            checkOutput("idle sck_o=cpol", sck_o, m[1]);
        end
        applyStimulus(8'h5A, 2'd0, 2'd1, 1'b1, LAT_WORD, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'h81, 2'd2, 2'd2, 1'b1, LAT_WORD, 1'b1, 1'b1);
        waitDrain();

        for (int k = 0; k < 2; k++) begin
            f0     = frames;
            minGap = 1000;
            applyStimulus(8'h12, 2'd0, (k == 0) ? 2'd0 : 2'd3, 1'b0, LAT_WORD, 1'b1, 1'b1);
`ifdef SPI_CS_HOLD_EN
            applyStimulus(8'h34, 2'd0, (k == 0) ? 2'd0 : 2'd3, 1'b1, LAT_CHAIN, 1'b1, 1'b0);
            waitDrain();
            checkOutput("chained frame count", frames - f0, 1);
`else
            applyStimulus(8'h34, 2'd0, (k == 0) ? 2'd0 : 2'd3, 1'b1, LAT_WORD, 1'b1, 1'b1);
            waitDrain();
            checkOutput("unchained frame count", frames - f0, 2);
            checkOutput("cs high gap >= CLK_DIV+1", minGap >= CD + 1, 1);
`endif
        end

        applyStimulus(8'hA5, 2'd1, 2'd0, 1'b1, LAT_WORD, 1'b0, 1'b0);
        repeat (8) @(negedge axi_aclk);
        @(posedge axi_aclk);
        #2 axi_aresetn = 1'b0;
        #1 checkResetValues("mid-shift reset");
        repeat (2) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        repeat (50) @(negedge axi_aclk);
        applyStimulus(8'h96, 2'd2, 2'd2, 1'b1, LAT_WORD, 1'b1, 1'b1);
        waitDrain();

        applyStimulus(8'h5A, 2'd3, 2'd0, 1'b1, LAT_WORD, 1'b1, 1'b1);
        waitDrain();

        checkOutput("final rsp queue empty", rspQ.size(), 0);
        checkOutput("final mosi queue empty", mosiQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
